// File: rtl/raster_pkg.sv
// Shared constants, channel map and packed-bus helpers for the raster per-line sequencer.
package raster_pkg;

    localparam int XACT  = 640;
    localparam int LINES = 480;
    localparam int EW    = 20;
    localparam int BW    = 22;
    localparam int NCH_E = 6;
    localparam int NCH_B = 4;
    localparam int NCH   = NCH_E + NCH_B;

    localparam logic [3:0] CH_E0   = 4'd0;
    localparam logic [3:0] CH_B0   = 4'd6;
    localparam logic [3:0] CH_LAST = 4'd9;

    typedef enum logic {
        S_IDLE,
        S_STEP
    } sched_state_t;

    function automatic logic [EW-1:0] e_slice(input logic [NCH_E*EW-1:0] bus, input int idx);
        return bus[idx*EW +: EW];
    endfunction

    function automatic logic [BW-1:0] b_slice(input logic [NCH_B*BW-1:0] bus, input int idx);
        return bus[idx*BW +: BW];
    endfunction

endpackage

// File: rtl/raster_chan_adder.sv
// Shared per-line adder: selects one channel's current value and step, adds at that channel's width.
module raster_chan_adder
    import raster_pkg::*;
(
    input  logic [3:0]          ch,
    input  logic [NCH_E*EW-1:0] e_cur,
    input  logic [NCH_E*EW-1:0] e_step,
    input  logic [NCH_B*BW-1:0] b_cur,
    input  logic [NCH_B*BW-1:0] b_step,
    output logic [BW-1:0]       sum
);

    logic [EW-1:0] ev;
    logic [EW-1:0] es;
    logic [BW-1:0] a;
    logic [BW-1:0] s;

    always_comb begin
        ev = '0;
        es = '0;
        a  = '0;
        s  = '0;
        if (ch < CH_B0) begin
            // Edge values are sign-extended so the upper bits of sum stay meaningful.
            ev = e_slice(e_cur, int'(ch));
            es = e_slice(e_step, int'(ch));
            a  = {{(BW-EW){ev[EW-1]}}, ev};
            s  = {{(BW-EW){es[EW-1]}}, es};
        end else begin
            a = b_slice(b_cur, int'(ch - CH_B0));
            s = b_slice(b_step, int'(ch - CH_B0));
        end
        sum = a + s;
    end

endmodule

// File: rtl/raster_line_sched.sv
// Per-line init sequencer: shadow/active frame setup plus a serial ten-channel step in each hblank.
module raster_line_sched
    import raster_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic [9:0]          x,
    input  logic [9:0]          y,
    input  logic                setup_valid,
    output logic                setup_ready,
    input  logic [NCH_E*EW-1:0] e_base,
    input  logic [NCH_E*EW-1:0] e_step,
    input  logic [NCH_B*BW-1:0] b_base,
    input  logic [NCH_B*BW-1:0] b_step,
    output logic [NCH_E*EW-1:0] e_init,
    output logic [NCH_B*BW-1:0] bar_init,
    output logic                frame_swap,
    output logic                busy,
    output logic                overrun
);

    sched_state_t        state_reg, state_next;
    logic [3:0]          ch_reg, ch_next;
    logic                pending_reg;
    logic                frame_swap_reg;
    logic                overrun_reg, overrun_next;
    logic [NCH_E*EW-1:0] sh_e_base_reg, sh_e_step_reg, act_e_base_reg, act_e_step_reg;
    logic [NCH_B*BW-1:0] sh_b_base_reg, sh_b_step_reg, act_b_base_reg, act_b_step_reg;
    logic [NCH_E*EW-1:0] e_init_reg, e_init_next;
    logic [NCH_B*BW-1:0] bar_init_reg, bar_init_next;
    logic [NCH-1:0]      wr_en;
    logic [BW-1:0]       sum;
    logic                hblank_x, commit, trigger, capture;

    assign hblank_x = (x == 10'(XACT + 1));
    assign commit   = hblank_x && (y == 10'(LINES - 1));
    assign trigger  = hblank_x && ((y < 10'(LINES - 1)) || (y == 10'(LINES)));
    assign capture  = setup_valid && !pending_reg;

    raster_chan_adder u_adder (
        .ch     (ch_reg),
        .e_cur  (e_init_reg),
        .e_step (act_e_step_reg),
        .b_cur  (bar_init_reg),
        .b_step (act_b_step_reg),
        .sum    (sum)
    );

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_wr
            assign wr_en[gi] = (state_reg == S_STEP) && (ch_reg == 4'(gi));
        end
    endgenerate

    always_comb begin
        e_init_next   = e_init_reg;
        bar_init_next = bar_init_reg;
        for (int i = 0; i < NCH_E; i++) begin
            if (wr_en[i]) e_init_next[i*EW +: EW] = sum[EW-1:0];
        end
        for (int i = 0; i < NCH_B; i++) begin
            if (wr_en[NCH_E+i]) bar_init_next[i*BW +: BW] = sum;
        end
        // Commit reloads line 0 from whichever set is active after this cycle.
        if (commit) begin
            e_init_next   = pending_reg ? sh_e_base_reg : act_e_base_reg;
            bar_init_next = pending_reg ? sh_b_base_reg : act_b_base_reg;
        end
    end

    always_comb begin
        state_next   = state_reg;
        ch_next      = ch_reg;
        overrun_next = overrun_reg;
        if (commit) begin
            state_next = S_IDLE;
            ch_next    = CH_E0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (trigger) begin
                        state_next = S_STEP;
                        ch_next    = CH_E0;
                    end
                end
                S_STEP: begin
                    if (trigger) overrun_next = 1'b1;
                    if (ch_reg == CH_LAST) begin
                        state_next = S_IDLE;
                        ch_next    = CH_E0;
                    end else begin
                        ch_next = ch_reg + 4'd1;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    ch_next    = CH_E0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= S_IDLE;
            ch_reg         <= '0;
            pending_reg    <= 1'b0;
            frame_swap_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            sh_e_base_reg  <= '0;
            sh_e_step_reg  <= '0;
            sh_b_base_reg  <= '0;
            sh_b_step_reg  <= '0;
            act_e_base_reg <= '0;
            act_e_step_reg <= '0;
            act_b_base_reg <= '0;
            act_b_step_reg <= '0;
            e_init_reg     <= '0;
            bar_init_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            ch_reg         <= ch_next;
            overrun_reg    <= overrun_next;
            frame_swap_reg <= commit && pending_reg;
            e_init_reg     <= e_init_next;
            bar_init_reg   <= bar_init_next;
            if (capture) begin
                sh_e_base_reg <= e_base;
                sh_e_step_reg <= e_step;
                sh_b_base_reg <= b_base;
                sh_b_step_reg <= b_step;
            end
            if (commit && pending_reg) begin
                act_e_base_reg <= sh_e_base_reg;
                act_e_step_reg <= sh_e_step_reg;
                act_b_base_reg <= sh_b_base_reg;
                act_b_step_reg <= sh_b_step_reg;
            end
            // A capture only happens with pending clear, so the two never collide.
            if (capture) pending_reg <= 1'b1;
            else if (commit && pending_reg) pending_reg <= 1'b0;
        end
    end

    assign setup_ready = !pending_reg;
    assign e_init      = e_init_reg;
    assign bar_init    = bar_init_reg;
    assign frame_swap  = frame_swap_reg;
    assign busy        = (state_reg == S_STEP);
    assign overrun     = overrun_reg;

endmodule

// File: tb/tb_raster_line_sched.sv
// Directed-vector bench for raster_line_sched; x/y are driven directly to reach hblank events quickly.
module tb_raster_line_sched;
    import raster_pkg::*;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [9:0]          x, y;
    logic                setup_valid;
    logic                setup_ready;
    logic [NCH_E*EW-1:0] e_base, e_step, e_init;
    logic [NCH_B*BW-1:0] b_base, b_step, bar_init;
    logic                frame_swap, busy, overrun;

    int errors = 0;
    int checks = 0;

    logic [NCH_E*EW-1:0] e_base1, e_step1, e_base2, e_step2, e_exp;
    logic [NCH_B*BW-1:0] b_base1, b_step1, b_exp;

    raster_line_sched dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .x           (x),
        .y           (y),
        .setup_valid (setup_valid),
        .setup_ready (setup_ready),
        .e_base      (e_base),
        .e_step      (e_step),
        .b_base      (b_base),
        .b_step      (b_step),
        .e_init      (e_init),
        .bar_init    (bar_init),
        .frame_swap  (frame_swap),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One hblank step: trigger edge, then count busy cycles until well past completion.
    task automatic do_line(input logic [9:0] ly, output int nbusy);
        x = 10'd641;
        y = ly;
        tick();
        x = 10'd100;
        nbusy = 0;
        for (int i = 0; i < 14; i++) begin
            if (busy) nbusy++;
            tick();
        end
        $display("step y=%0d busy_cycles=%0d e0=%h bar_iy=%h", ly, nbusy, e_init[19:0], bar_init[21:0]);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        x = 10'd300;
        y = 10'd20;
        #23;
        checks++; if (e_init !== '0) begin $display("FAIL reset_e_init got=%h exp=0", e_init); errors++; end
        checks++; if (bar_init !== '0) begin $display("FAIL reset_bar_init got=%h exp=0", bar_init); errors++; end
        checks++; if (setup_ready !== 1'b1) begin $display("FAIL reset_setup_ready got=%b exp=1", setup_ready); errors++; end
        checks++; if (frame_swap !== 1'b0) begin $display("FAIL reset_frame_swap got=%b exp=0", frame_swap); errors++; end
        checks++; if (busy !== 1'b0) begin $display("FAIL reset_busy got=%b exp=0", busy); errors++; end
        checks++; if (overrun !== 1'b0) begin $display("FAIL reset_overrun got=%b exp=0", overrun); errors++; end
        tick();
        reset_n = 1'b1;
        tick();
        $display("reset released");
    endtask

    task automatic test_first_frame();
        int nb;
        x = 10'd641;
        y = 10'd479;
        tick();
        x = 10'd100;
        checks++; if (frame_swap !== 1'b0) begin $display("FAIL empty_commit_swap got=%b exp=0", frame_swap); errors++; end
        checks++; if (e_init !== '0) begin $display("FAIL empty_commit_e_init got=%h exp=0", e_init); errors++; end
        do_line(10'd480, nb);
        checks++; if (e_init !== '0) begin $display("FAIL empty_step_e_init got=%h exp=0", e_init); errors++; end
        checks++; if (nb !== 10) begin $display("FAIL empty_step_busy got=%0d exp=10", nb); errors++; end
    endtask

    task automatic test_setup_commit();
        int nb;
        x = 10'd5;
        y = 10'd10;
        e_base = e_base1;
        e_step = e_step1;
        b_base = b_base1;
        b_step = b_step1;
        setup_valid = 1'b1;
        tick();
        $display("setup offered ready_after=%b", setup_ready);
        checks++; if (setup_ready !== 1'b0) begin $display("FAIL setup_ready_after_capture got=%b exp=0", setup_ready); errors++; end
        // Second offer while pending must be ignored.
        e_base = {100'd0, 20'h12345};
        tick();
        setup_valid = 1'b0;
        checks++; if (e_init !== '0) begin $display("FAIL precommit_e_init got=%h exp=0", e_init); errors++; end
        x = 10'd641;
        y = 10'd479;
        tick();
        x = 10'd100;
        $display("commit frame_swap=%b e0=%h", frame_swap, e_init[19:0]);
        checks++; if (frame_swap !== 1'b1) begin $display("FAIL commit_swap got=%b exp=1", frame_swap); errors++; end
        checks++; if (e_init !== e_base1) begin $display("FAIL commit_e_init got=%h exp=%h", e_init, e_base1); errors++; end
        checks++; if (bar_init !== b_base1) begin $display("FAIL commit_bar_init got=%h exp=%h", bar_init, b_base1); errors++; end
        checks++; if (setup_ready !== 1'b1) begin $display("FAIL commit_setup_ready got=%b exp=1", setup_ready); errors++; end
        tick();
        checks++; if (frame_swap !== 1'b0) begin $display("FAIL swap_one_cycle got=%b exp=0", frame_swap); errors++; end
        do_line(10'd480, nb);
        e_exp = {20'h0, 20'h0, 20'h80000, 20'h0, 20'h0, 20'hFFF9F};
        b_exp = {22'h200000, 22'h0, 22'h0, 22'h010100};
        checks++; if (e_init !== e_exp) begin $display("FAIL step480_e_init got=%h exp=%h", e_init, e_exp); errors++; end
        checks++; if (bar_init !== b_exp) begin $display("FAIL step480_bar_init got=%h exp=%h", bar_init, b_exp); errors++; end
        checks++; if (nb !== 10) begin $display("FAIL step480_busy got=%0d exp=10", nb); errors++; end
        do_line(10'd0, nb);
        e_exp = {20'h0, 20'h0, 20'h80001, 20'h0, 20'h0, 20'hFFFA2};
        b_exp = {22'h200001, 22'h0, 22'h0, 22'h010200};
        checks++; if (e_init !== e_exp) begin $display("FAIL step0_e_init got=%h exp=%h", e_init, e_exp); errors++; end
        checks++; if (bar_init !== b_exp) begin $display("FAIL step0_bar_init got=%h exp=%h", bar_init, b_exp); errors++; end
    endtask

    task automatic test_bar_stepping();
        int nb;
        logic [21:0] bexp;
        logic [19:0] eexp;
        for (int n = 1; n <= 4; n++) begin
            x = 10'd640;
            y = 10'(n);
            tick();
            bexp = 22'h010000 + 22'((n + 1) * 'h100);
            eexp = 20'(-100 + (n + 1) * 3);
            checks++; if (bar_init[21:0] !== bexp) begin $display("FAIL sample_bar_iy y=%0d got=%h exp=%h", n, bar_init[21:0], bexp); errors++; end
            checks++; if (e_init[19:0] !== eexp) begin $display("FAIL sample_e0 y=%0d got=%h exp=%h", n, e_init[19:0], eexp); errors++; end
            do_line(10'(n), nb);
            checks++; if (nb !== 10) begin $display("FAIL step_busy y=%0d got=%0d exp=10", n, nb); errors++; end
        end
        // y=481 lies beyond the step window.
        x = 10'd641;
        y = 10'd481;
        tick();
        x = 10'd100;
        checks++; if (busy !== 1'b0) begin $display("FAIL no_trigger_481 busy=%b exp=0", busy); errors++; end
        checks++; if (overrun !== 1'b0) begin $display("FAIL overrun_clear got=%b exp=0", overrun); errors++; end
    endtask

    task automatic test_collision();
        int nb;
        e_base = e_base2;
        e_step = e_step2;
        b_base = '0;
        b_step = '0;
        setup_valid = 1'b1;
        x = 10'd641;
        y = 10'd479;
        tick();
        setup_valid = 1'b0;
        x = 10'd100;
        $display("collision commit frame_swap=%b ready=%b e0=%h", frame_swap, setup_ready, e_init[19:0]);
        checks++; if (frame_swap !== 1'b0) begin $display("FAIL collide_swap got=%b exp=0", frame_swap); errors++; end
        checks++; if (e_init !== e_base1) begin $display("FAIL collide_e_init got=%h exp=%h", e_init, e_base1); errors++; end
        checks++; if (bar_init !== b_base1) begin $display("FAIL collide_bar_init got=%h exp=%h", bar_init, b_base1); errors++; end
        checks++; if (setup_ready !== 1'b0) begin $display("FAIL collide_pending got=%b exp=0", setup_ready); errors++; end
        tick();
        x = 10'd641;
        y = 10'd479;
        tick();
        x = 10'd100;
        checks++; if (frame_swap !== 1'b1) begin $display("FAIL next_commit_swap got=%b exp=1", frame_swap); errors++; end
        checks++; if (e_init !== e_base2) begin $display("FAIL next_commit_e_init got=%h exp=%h", e_init, e_base2); errors++; end
        checks++; if (bar_init !== '0) begin $display("FAIL next_commit_bar_init got=%h exp=0", bar_init); errors++; end
        do_line(10'd480, nb);
        e_exp = {100'd0, 20'd57};
        checks++; if (e_init !== e_exp) begin $display("FAIL collide_step_e_init got=%h exp=%h", e_init, e_exp); errors++; end
    endtask

    task automatic test_overrun();
        int nb;
        x = 10'd641;
        y = 10'd480;
        tick();
        nb = 0;
        for (int i = 0; i < 15; i++) begin
            if (busy) nb++;
            x = (i == 4) ? 10'd641 : 10'd100;
            tick();
        end
        x = 10'd100;
        $display("overrun step busy_cycles=%0d overrun=%b e0=%h", nb, overrun, e_init[19:0]);
        e_exp = {100'd0, 20'd64};
        checks++; if (overrun !== 1'b1) begin $display("FAIL overrun_set got=%b exp=1", overrun); errors++; end
        checks++; if (nb !== 10) begin $display("FAIL overrun_busy got=%0d exp=10", nb); errors++; end
        checks++; if (e_init !== e_exp) begin $display("FAIL overrun_e_init got=%h exp=%h", e_init, e_exp); errors++; end
        repeat (5) tick();
        checks++; if (overrun !== 1'b1) begin $display("FAIL overrun_sticky got=%b exp=1", overrun); errors++; end
    endtask

    task automatic test_reset_mid_step();
        x = 10'd641;
        y = 10'd480;
        tick();
        x = 10'd100;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        $display("reset mid-step busy=%b e0=%h", busy, e_init[19:0]);
        checks++; if (e_init !== '0) begin $display("FAIL midreset_e_init got=%h exp=0", e_init); errors++; end
        checks++; if (bar_init !== '0) begin $display("FAIL midreset_bar_init got=%h exp=0", bar_init); errors++; end
        checks++; if (busy !== 1'b0) begin $display("FAIL midreset_busy got=%b exp=0", busy); errors++; end
        checks++; if (overrun !== 1'b0) begin $display("FAIL midreset_overrun got=%b exp=0", overrun); errors++; end
        checks++; if (setup_ready !== 1'b1) begin $display("FAIL midreset_ready got=%b exp=1", setup_ready); errors++; end
        #1;
        reset_n = 1'b1;
        tick();
        x = 10'd641;
        y = 10'd479;
        tick();
        x = 10'd100;
        checks++; if (e_init !== '0) begin $display("FAIL post_reset_commit_e_init got=%h exp=0", e_init); errors++; end
        checks++; if (frame_swap !== 1'b0) begin $display("FAIL post_reset_commit_swap got=%b exp=0", frame_swap); errors++; end
    endtask

    initial begin
        reset_n     = 1'b0;
        x           = '0;
        y           = '0;
        setup_valid = 1'b0;
        e_base      = '0;
        e_step      = '0;
        b_base      = '0;
        b_step      = '0;
        e_base1 = {20'h0, 20'h0, 20'h7FFFF, 20'h0, 20'h0, 20'hFFF9C};
        e_step1 = {20'h0, 20'h0, 20'h00001, 20'h0, 20'h0, 20'h00003};
        b_base1 = {22'h1FFFFF, 22'h0, 22'h0, 22'h010000};
        b_step1 = {22'h000001, 22'h0, 22'h0, 22'h000100};
        e_base2 = {100'd0, 20'd50};
        e_step2 = {100'd0, 20'd7};

        test_reset();
        test_first_frame();
        test_setup_commit();
        test_bar_stepping();
        test_collision();
        test_overrun();
        test_reset_mid_step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
